// File: rtl/board_scanner.sv
// board_scanner: snapshots an 81-cell board and streams it out one cell per
// accepted transfer in row-major order. At the end of each frame it reports
// a per-frame summary: solved, has_error and revealed_count.
//
// Handshake: cell_valid/cell_ready. A transfer happens on a rising clock edge
// where cell_valid=1 and cell_ready=1. Once cell_valid is high, the row, col,
// digit and status outputs hold until that transfer. A stall may last any
// number of cycles. cell_valid never drops without a transfer, except on
// reset.
module board_scanner #(
    parameter bit         AUTO_RESTART = 1'b0,
    parameter logic [3:0] HIDDEN_DIGIT = 4'd0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [323:0] board,
    input  logic [161:0] visibilities,
    input  logic         cell_ready,
    output logic         cell_valid,
    output logic [3:0]   cell_row,
    output logic [3:0]   cell_col,
    output logic [3:0]   cell_digit,
    output logic [1:0]   cell_status,
    output logic         busy,
    output logic         frame_done,
    output logic         solved,
    output logic         has_error,
    output logic [6:0]   revealed_count,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [323:0]   r_snap_board;
    logic [161:0]   r_snap_vis;
    logic [3:0]     r_row;
    logic [3:0]     r_col;
    logic [6:0]     r_idx;        // linear index 9*row+col, kept to avoid a multiplier
    logic [6:0]     r_count;      // running count of revealed cells
    logic           r_err;        // running "saw an error cell" flag
    logic           r_valid;
    logic [3:0]     r_digit;
    logic [1:0]     r_status;
    logic           r_frame_done;
    logic           r_solved;
    logic           r_has_error;
    logic [6:0]     r_revealed;

    logic           w_xfer;
    logic           w_last;
    logic           w_begin;
    logic [6:0]     w_fetch_idx;
    logic [3:0]     w_fetch_digit;
    logic [1:0]     w_fetch_status;
    logic [6:0]     w_count_next;
    logic           w_err_next;

    // Error and revealed cells show their number; hidden and cursor cells do not.
    function automatic logic [3:0] shown_digit(input logic [1:0] st, input logic [3:0] dg);
        return st[1] ? dg : HIDDEN_DIGIT;
    endfunction

    assign w_xfer  = r_valid & cell_ready;
    assign w_last  = (r_row == 4'd8) && (r_col == 4'd8);
    // A new frame starts from IDLE on start, or straight out of DONE when auto-restarting.
    assign w_begin = ((r_state == ST_IDLE) && start) || ((r_state == ST_DONE) && AUTO_RESTART);

    // Next cell to present. It is forced to 0 on the last cell so the select stays in range.
    assign w_fetch_idx    = w_last ? 7'd0 : (r_idx + 7'd1);
    assign w_fetch_digit  = r_snap_board[{w_fetch_idx, 2'b00} +: 4];
    assign w_fetch_status = r_snap_vis[{w_fetch_idx, 1'b0} +: 2];

    // The running totals include the cell being transferred this cycle.
    assign w_count_next = r_count + {6'd0, (r_status == 2'b11)};
    assign w_err_next   = r_err | (r_status == 2'b10);

    // Scan FSM: snapshot on frame start, then step through cells on transfers and publish the summary at the end.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_snap_board <= '0;
            r_snap_vis   <= '0;
            r_row        <= 4'd0;
            r_col        <= 4'd0;
            r_idx        <= 7'd0;
            r_count      <= 7'd0;
            r_err        <= 1'b0;
            r_valid      <= 1'b0;
            r_digit      <= 4'd0;
            r_status     <= 2'b00;
            r_frame_done <= 1'b0;
            r_solved     <= 1'b0;
            r_has_error  <= 1'b0;
            r_revealed   <= 7'd0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_begin) begin
                        r_snap_board <= board;
                        r_snap_vis   <= visibilities;
                        r_row        <= 4'd0;
                        r_col        <= 4'd0;
                        r_idx        <= 7'd0;
                        r_count      <= 7'd0;
                        r_err        <= 1'b0;
                        r_valid      <= 1'b1;
                        r_digit      <= shown_digit(visibilities[1:0], board[3:0]);
                        r_status     <= visibilities[1:0];
                        r_state      <= ST_SEND;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (w_xfer) begin
                        r_count <= w_count_next;
                        r_err   <= w_err_next;
                        if (w_last) begin
                            r_valid      <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_solved     <= (w_count_next == 7'd81);
                            r_has_error  <= w_err_next;
                            r_revealed   <= w_count_next;
                            r_state      <= ST_DONE;
                        end else begin
                            r_idx    <= w_fetch_idx;
                            r_digit  <= shown_digit(w_fetch_status, w_fetch_digit);
                            r_status <= w_fetch_status;
                            if (r_col == 4'd8) begin
                                r_col <= 4'd0;
                                r_row <= r_row + 4'd1;
                            end else begin
                                r_col <= r_col + 4'd1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cell_valid     = r_valid;
    assign cell_row       = r_row;
    assign cell_col       = r_col;
    assign cell_digit     = r_digit;
    assign cell_status    = r_status;
    assign busy           = (r_state != ST_IDLE);
    assign frame_done     = r_frame_done;
    assign solved         = r_solved;
    assign has_error      = r_has_error;
    assign revealed_count = r_revealed;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_board_scanner.sv
// Bench for board_scanner. The reference model turns a board/visibility
// snapshot into the expected cell stream and frame summary.
module tb_board_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [323:0] board;
    logic [161:0] visibilities;
    logic         start_a, ready_a, start_b, ready_b;

    logic         a_valid, a_busy, a_frame_done, a_solved, a_has_error;
    logic [3:0]   a_row, a_col, a_digit;
    logic [1:0]   a_status, a_dbg;
    logic [6:0]   a_rev;

    logic         b_valid, b_busy, b_frame_done, b_solved, b_has_error;
    logic [3:0]   b_row, b_col, b_digit;
    logic [1:0]   b_status, b_dbg;
    logic [6:0]   b_rev;

    board_scanner #(.AUTO_RESTART(1'b0), .HIDDEN_DIGIT(4'd0)) u_dut (
        .clk(clk), .reset(reset), .start(start_a), .board(board),
        .visibilities(visibilities), .cell_ready(ready_a),
        .cell_valid(a_valid), .cell_row(a_row), .cell_col(a_col),
        .cell_digit(a_digit), .cell_status(a_status), .busy(a_busy),
        .frame_done(a_frame_done), .solved(a_solved), .has_error(a_has_error),
        .revealed_count(a_rev), .dbg_state(a_dbg)
    );

    board_scanner #(.AUTO_RESTART(1'b1), .HIDDEN_DIGIT(4'hF)) u_dut_ar (
        .clk(clk), .reset(reset), .start(start_b), .board(board),
        .visibilities(visibilities), .cell_ready(ready_b),
        .cell_valid(b_valid), .cell_row(b_row), .cell_col(b_col),
        .cell_digit(b_digit), .cell_status(b_status), .busy(b_busy),
        .frame_done(b_frame_done), .solved(b_solved), .has_error(b_has_error),
        .revealed_count(b_rev), .dbg_state(b_dbg)
    );

    int checks = 0;
    int failures = 0;

    logic [3:0]  bd[81];
    logic [1:0]  vs[81];
    logic [13:0] exp_q[$];
    int          exp_count;
    logic        exp_err;
    logic        exp_solved;
    logic [6:0]  prev_count;
    logic        prev_solved;
    logic        prev_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_inputs();
        for (int k = 0; k < 81; k++) begin
            board[4*k +: 4]        = bd[k];
            visibilities[2*k +: 2] = vs[k];
        end
    endtask

    // Expected stream: row = k/9, col = k%9; only error/revealed cells show the digit.
    task automatic build_model(input logic [3:0] hid);
        logic [3:0] r4, c4, dg;
        exp_q.delete();
        exp_count = 0;
        exp_err   = 1'b0;
        for (int k = 0; k < 81; k++) begin
            r4 = 4'(k / 9);
            c4 = 4'(k % 9);
            dg = (vs[k] == 2'b11 || vs[k] == 2'b10) ? bd[k] : hid;
            exp_q.push_back({r4, c4, dg, vs[k]});
            if (vs[k] == 2'b11) exp_count++;
            if (vs[k] == 2'b10) exp_err = 1'b1;
        end
        exp_solved = (exp_count == 81);
    endtask

    task automatic randomize_pattern(input bit all_revealed);
        for (int k = 0; k < 81; k++) begin
            bd[k] = 4'($urandom_range(0, 15));
            vs[k] = all_revealed ? 2'b11 : 2'($urandom_range(0, 3));
        end
    endtask

    task automatic check_reset_a();
        check("rst_valid", a_valid, 0);
        check("rst_busy", a_busy, 0);
        check("rst_frame_done", a_frame_done, 0);
        check("rst_row", a_row, 0);
        check("rst_col", a_col, 0);
        check("rst_digit", a_digit, 0);
        check("rst_status", a_status, 0);
        check("rst_solved", a_solved, 0);
        check("rst_has_error", a_has_error, 0);
        check("rst_revealed", a_rev, 0);
        check("rst_state", a_dbg, 0);
    endtask

    task automatic start_pulse_a();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    // Called at the first negedge after the start edge. Returns at the negedge showing frame_done.
    task automatic collect_frame(input int stall_pct, input bit scramble,
                                 input bit poke_start, input bit check_latency);
        int          cyc;
        bit          finished;
        bit          stalled;
        logic [13:0] cur, held, e;
        cyc = 0; finished = 0; stalled = 0; held = '0;
        while (!finished && cyc < 3000) begin
            cur = {a_row, a_col, a_digit, a_status};
            if (cyc == 0) begin
                check("valid_after_start", a_valid, 1);
                check("hold_solved", a_solved, prev_solved);
                check("hold_has_error", a_has_error, prev_err);
                check("hold_revealed", a_rev, prev_count);
            end
            if (a_frame_done) begin
                if (check_latency) check("done_latency", cyc, 81);
                check("cells_left", exp_q.size(), 0);
                check("done_valid_low", a_valid, 0);
                check("done_busy", a_busy, 1);
                check("solved", a_solved, exp_solved);
                check("has_error", a_has_error, exp_err);
                check("revealed_count", a_rev, exp_count);
                prev_solved = exp_solved;
                prev_err    = exp_err;
                prev_count  = 7'(exp_count);
                finished = 1;
            end else if (a_valid) begin
                if (stalled) check("stall_hold", cur, held);
                ready_a = ($urandom_range(0, 99) >= stall_pct);
                if (ready_a) begin
                    if (exp_q.size() == 0) check("extra_cell", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("cell", cur, e);
                    end
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = cur;
                end
            end else begin
                check("valid_dropped", a_valid, 1);
            end
            start_a = poke_start && (cyc == 20 || cyc == 21);
            if (scramble) begin
                for (int k = 0; k < 81; k++) begin
                    board[4*k +: 4]        = 4'($urandom_range(0, 15));
                    visibilities[2*k +: 2] = 2'($urandom_range(0, 3));
                end
            end
            if (!finished) begin
                @(negedge clk);
                cyc++;
            end
        end
        start_a = 1'b0;
        if (!finished) check("frame_timeout", 0, 1);
    endtask

    task automatic idle_after_a();
        @(negedge clk);
        check("post_done_pulse", a_frame_done, 0);
        check("post_done_busy", a_busy, 0);
        check("post_done_valid", a_valid, 0);
        check("post_done_state", a_dbg, 0);
    endtask

    initial begin
        int n, nv, spurious;
        logic [13:0] e;
        reset = 1'b0; start_a = 0; ready_a = 0; start_b = 0; ready_b = 0;
        board = '0; visibilities = '0;
        prev_solved = 0; prev_err = 0; prev_count = 0;
        repeat (3) @(negedge clk);
        check_reset_a();
        check("rst_b_valid", b_valid, 0);
        check("rst_b_digit", b_digit, 0);
        reset = 1'b1;
        @(negedge clk);

        // Fully revealed board, digits 1..9 per row, no stalls.
        // frame_done appears 81 edges after the start edge (cycle 83 counting the start cycle as 1).
        for (int k = 0; k < 81; k++) begin bd[k] = 4'(k % 9 + 1); vs[k] = 2'b11; end
        load_inputs(); build_model(4'd0);
        ready_a = 1'b1;
        start_pulse_a();
        collect_frame(0, 0, 0, 1);
        check("t1_solved", a_solved, 1);
        check("t1_count", a_rev, 81);
        check("t1_error", a_has_error, 0);
        idle_after_a();

        // Hidden centre cell and an error cell in the corner.
        randomize_pattern(1);
        bd[40] = 4'd7; vs[40] = 2'b00; vs[0] = 2'b10;
        load_inputs(); build_model(4'd0);
        start_pulse_a();
        collect_frame(0, 0, 0, 1);
        check("t2_solved", a_solved, 0);
        check("t2_error", a_has_error, 1);
        check("t2_count", a_rev, 79);
        idle_after_a();

        // Random frames with stalls and mid-frame input changes; one with a stray start.
        for (int f = 0; f < 4; f++) begin
            randomize_pattern(f == 1);
            load_inputs(); build_model(4'd0);
            start_pulse_a();
            collect_frame(40, 1, f == 2, 0);
            idle_after_a();
            if (f == 2) begin
                spurious = 0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (a_valid || a_frame_done || a_busy) spurious++;
                end
                check("stray_start_ignored", spurious, 0);
            end
        end

        // Start held high: one DONE and one IDLE cycle between the 81 SEND cycles.
        for (int k = 0; k < 81; k++) begin bd[k] = 4'(k % 16); vs[k] = 2'b11; end
        load_inputs();
        ready_a = 1'b1;
        @(negedge clk);
        start_a = 1'b1;
        n = 0;
        while (!a_frame_done && n < 300) begin @(negedge clk); n++; end
        check("thru_first_done", a_frame_done, 1);
        n = 0; nv = 0;
        do begin
            @(negedge clk);
            n++;
            if (a_valid) nv++;
        end while (!a_frame_done && n < 300);
        check("thru_period", n, 83);
        check("thru_send_cycles", nv, 81);
        start_a = 1'b0;
        n = 0;
        while (a_busy && n < 300) begin @(negedge clk); n++; end
        check("thru_stop", a_busy, 0);
        prev_solved = 1; prev_err = 0; prev_count = 7'd81;

        // Auto-restart instance: back-to-back frames, each on a fresh snapshot.
        randomize_pattern(0);
        load_inputs(); build_model(4'hF);
        ready_b = 1'b1;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int fr = 0; fr < 2; fr++) begin
            for (int c = 0; c < 81; c++) begin
                check("b_valid", b_valid, 1);
                e = exp_q.pop_front();
                check("b_cell", {b_row, b_col, b_digit, b_status}, e);
                @(negedge clk);
            end
            check("b_done", b_frame_done, 1);
            check("b_done_valid_low", b_valid, 0);
            check("b_solved", b_solved, exp_solved);
            check("b_has_error", b_has_error, exp_err);
            check("b_revealed", b_rev, exp_count);
            randomize_pattern(fr == 0);
            load_inputs(); build_model(4'hF);
            @(negedge clk);
        end
        check("b_restart_valid", b_valid, 1);

        // Reset in the middle of a frame, while row 3 is being sent.
        for (int k = 0; k < 81; k++) begin bd[k] = 4'(k % 9 + 1); vs[k] = 2'b11; end
        load_inputs();
        ready_a = 1'b1;
        start_pulse_a();
        n = 0;
        while (a_row != 4'd3 && n < 100) begin @(negedge clk); n++; end
        check("reached_row3", a_row, 3);
        #2 reset = 1'b0;
        #1 check_reset_a();
        check("rst_b_valid_mid", b_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        prev_solved = 0; prev_err = 0; prev_count = 0;
        spurious = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_valid || a_frame_done || a_busy) spurious++;
        end
        check("no_activity_after_reset", spurious, 0);
        check("post_reset_solved", a_solved, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/board_scanner.md
BOARD_SCANNER -- requirements
Module: board_scanner

Interface
REQ-001 Parameter AUTO_RESTART, default 0: when 1, a new frame begins automatically after DONE without waiting for start.
REQ-002 Parameter HIDDEN_DIGIT, default 4'd0: digit value emitted for cells that must not show their number.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted (low) forces the reset state immediately, released synchronously to clk.
REQ-005 start  input  1  request one full-board scan; sampled only in IDLE.
REQ-006 board  input  324  cell k (k=0..80, row-major, k=9*row+col) digit at board[4k+:4].
REQ-007 visibilities  input  162  cell k status at visibilities[2k+:2]: 00 hidden, 01 cursor, 10 error, 11 revealed.
REQ-008 cell_ready  input  1  downstream display driver accepts the current cell.
REQ-009 cell_valid  output  1  current cell outputs are valid.
REQ-010 cell_row, cell_col  output  4 each  row/column (0..8) of the current cell.
REQ-011 cell_digit  output  4  digit to display, or HIDDEN_DIGIT.
REQ-012 cell_status  output  2  visibility code of the current cell, copied from the snapshot.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 frame_done  output  1  one-cycle pulse after the last cell is accepted.
REQ-015 solved  output  1  last completed frame had all 81 cells at status 11.
REQ-016 has_error  output  1  last completed frame had at least one cell at status 10.
REQ-017 revealed_count  output  7  number of status-11 cells in the last completed frame (0..81).

Function
REQ-018 The FSM SHALL have exactly three states, IDLE, SEND and DONE, encoded in 2 bits.
REQ-019 IDLE: when start=1 at a rising edge, capture board and visibilities into internal snapshot registers, clear the running counters, set row=col=0, and enter SEND; cell_valid rises in the first cycle after start is sampled.
REQ-020 SEND: cell_valid=1, and the cell outputs SHALL come only from the snapshot; changes on board/visibilities during a frame SHALL NOT affect the frame.
REQ-021 cell_digit = snapshot digit when status is 11 or 10; HIDDEN_DIGIT when status is 00 or 01.
REQ-022 Handshake: a transfer occurs on a rising edge with cell_valid&cell_ready; the outputs SHALL hold stable while cell_valid=1 and cell_ready=0, with no limit on stall length.
REQ-023 On each transfer, col increments; when col=8, col wraps to 0 and row increments.
REQ-024 On the transfer of cell (8,8), enter DONE; row/col SHALL never exceed 8.
REQ-025 Running counters update on each transfer: the reveal counter adds 1 for status 11, and the error flag is set for status 10; the counter is 7 bits and cannot overflow (maximum 81).
REQ-026 DONE lasts exactly one cycle: frame_done=1; solved, has_error and revealed_count load from the running values (solved = count==81); next state is IDLE, or SEND with a fresh snapshot when AUTO_RESTART=1.
REQ-027 solved, has_error and revealed_count SHALL hold between DONE cycles.
REQ-028 start=1 outside IDLE SHALL be ignored and not queued; start held high continuously starts a new frame on each return to IDLE.
REQ-029 Throughput with cell_ready tied high: 81 SEND cycles, 1 DONE cycle, 1 IDLE cycle per frame (AUTO_RESTART=0).

Reset
REQ-030 While reset=0: state=IDLE, cell_valid=0, busy=0, frame_done=0, row=col=0, cell_digit=0, cell_status=00, solved=0, has_error=0, revealed_count=0, counters and snapshot cleared.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no frame_done pulse and no update of solved/has_error/revealed_count.

Verification
REQ-032 All 81 cells at status 11 with digit=(k%9)+1, cell_ready=1, one start pulse -> 81 transfers in row-major order with digits 1..9 repeating, frame_done on cycle 83 after start, solved=1, revealed_count=81, has_error=0.
REQ-033 Cell 40 at status 00 with digit 7, cell 0 at status 10, all other cells 11 -> cell (4,4) emits digit 0 with status 00; solved=0, has_error=1, revealed_count=79.
REQ-034 cell_ready toggled randomly and board rewritten mid-frame -> output sequence identical to the no-stall run on the start-time snapshot; outputs stable during every stall.
REQ-035 reset driven low while row=3 -> outputs immediately at reset values; after release no cell_valid until the next start.
REQ-036 start pulsed during SEND -> ignored, exactly one frame_done; with AUTO_RESTART=1 -> back-to-back frames, cell_valid low only during the DONE cycle.
